// File: rtl/dmem_pkg.sv
// Shared types and constants for the four-lane byte-sliced data memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int LANES      = 4;
    localparam int WORD_IDX_W = 14;
    localparam int MEM_WORDS  = 16384;

    // Number of bytes moved by an access; an illegal size covers no lanes.
    function automatic logic [2:0] size_bytes(input size_e sz);
        case (sz)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            SZ_W:    size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: per-lane word addresses and enables, store byte
// rotation, load byte gather with sign/zero extension, and access error detection.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter bit MISALIGN_EN = 1'b1,
    parameter int ADDR_W      = 16
) (
    input  logic [ADDR_W-1:0]             addr_i,
    input  size_e                         size_i,
    input  logic                          unsigned_i,
    input  logic [31:0]                   wdata_i,
    input  logic [31:0]                   rdata_i,
    output logic [LANES*WORD_IDX_W-1:0]   lane_addr_o,
    output logic [LANES-1:0]              lane_en_o,
    output logic [31:0]                   lane_wdata_o,
    output logic [31:0]                   load_data_o,
    output logic                          err_o
);

    logic [1:0]            off;
    logic [WORD_IDX_W-1:0] word;
    logic [WORD_IDX_W-1:0] word_nxt;
    logic [2:0]            nbytes;
    logic [2:0]            pos;
    logic [1:0]            lane;
    logic [31:0]           gathered;
    logic                  wrap_any;
    logic                  misaligned;
    logic                  sign_b;
    logic                  sign_h;

    // Byte b of the access lives in lane (off+b)&3; bytes past the word boundary
    // land in the next word of their lane.
    always_comb begin
        off          = addr_i[1:0];
        word         = addr_i[ADDR_W-1:2];
        word_nxt     = word + WORD_IDX_W'(1);
        nbytes       = size_bytes(size_i);
        lane_addr_o  = {LANES{word}};
        lane_en_o    = '0;
        lane_wdata_o = '0;
        gathered     = '0;
        wrap_any     = 1'b0;
        pos          = '0;
        lane         = '0;
        for (int b = 0; b < LANES; b++) begin
            if (3'(b) < nbytes) begin
                pos  = {1'b0, off} + 3'(b);
                lane = pos[1:0];
                lane_en_o[lane] = 1'b1;
                lane_addr_o[lane*WORD_IDX_W +: WORD_IDX_W] = pos[2] ? word_nxt : word;
                lane_wdata_o[lane*8 +: 8] = wdata_i[b*8 +: 8];
                gathered[b*8 +: 8]        = rdata_i[lane*8 +: 8];
                wrap_any = wrap_any | pos[2];
            end
        end
    end

    always_comb begin
        misaligned = ((size_i == SZ_H) && off[0]) || ((size_i == SZ_W) && (off != 2'b00));
        // The top word has no successor; crossing it is an error rather than a wrap.
        err_o = (size_i == SZ_ILL)
              || (!MISALIGN_EN && misaligned)
              || (wrap_any && (word == WORD_IDX_W'(MEM_WORDS - 1)));
    end

    always_comb begin
        sign_b = !unsigned_i && gathered[7];
        sign_h = !unsigned_i && gathered[15];
        case (size_i)
            SZ_B:    load_data_o = {{24{sign_b}}, gathered[7:0]};
            SZ_H:    load_data_o = {{16{sign_h}}, gathered[15:0]};
            default: load_data_o = gathered;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Single-outstanding load/store controller for the four-lane data memory:
// accept, one RAM beat, then hold the response until it is consumed.
module dmem_lsu_ctrl
    import dmem_pkg::*;
#(
    parameter bit MISALIGN_EN = 1'b1,
    parameter int ADDR_W      = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_we_i,
    input  logic [ADDR_W-1:0]           req_addr_i,
    input  logic [1:0]                  req_size_i,
    input  logic                        req_unsigned_i,
    input  logic [31:0]                 req_wdata_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [31:0]                 rsp_rdata_o,
    output logic                        rsp_err_o,
    output logic [LANES*WORD_IDX_W-1:0] ram_addr_o,
    output logic [LANES-1:0]            ram_wren_o,
    output logic [31:0]                 ram_wdata_o,
    input  logic [31:0]                 ram_rdata_i
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    size_e             size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [LANES-1:0]  lane_en;
    logic [31:0]       load_data;
    logic              align_err;

    dmem_lane_align #(
        .MISALIGN_EN (MISALIGN_EN),
        .ADDR_W      (ADDR_W)
    ) u_align (
        .addr_i       (addr_q),
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .wdata_i      (wdata_q),
        .rdata_i      (ram_rdata_i),
        .lane_addr_o  (ram_addr_o),
        .lane_en_o    (lane_en),
        .lane_wdata_o (ram_wdata_o),
        .load_data_o  (load_data),
        .err_o        (align_err)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        we_d        = we_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    size_d  = size_e'(req_size_i);
                    we_d    = req_we_i;
                    uns_d   = req_unsigned_i;
                    wdata_d = req_wdata_i;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Stores and faulted accesses report zero data.
                rsp_rdata_d = (we_q || align_err) ? 32'd0 : load_data;
                rsp_err_d   = align_err;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            size_q      <= SZ_B;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Write enables come straight from the state flop so a reset kills them immediately.
    assign ram_wren_o  = ((state_q == ACCESS) && we_q && !align_err) ? lane_en : '0;
    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: lane RAMs modelled here, results compared
// against a flat byte-addressed reference memory.
module tb_dmem_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0, rsp_ready = 1'b0;
    logic [15:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, ram_wdata, ram_rdata;
    logic [55:0] ram_addr;
    logic [3:0]  ram_wren;

    logic        d0_req_valid = 1'b0, d0_rsp_ready = 1'b0;
    logic [15:0] d0_req_addr = '0;
    logic [31:0] d0_req_wdata = '0;
    logic        d0_req_ready, d0_rsp_valid, d0_rsp_err;
    logic [31:0] d0_rsp_rdata, d0_ram_wdata;
    logic [31:0] d0_ram_rdata = '0;
    logic [55:0] d0_ram_addr;
    logic [3:0]  d0_ram_wren;

    dmem_lsu_ctrl #(.MISALIGN_EN(1'b1), .ADDR_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_uns),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err),
        .ram_addr_o(ram_addr), .ram_wren_o(ram_wren), .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata)
    );

    dmem_lsu_ctrl #(.MISALIGN_EN(1'b0), .ADDR_W(16)) dut_noalign (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(d0_req_valid), .req_ready_o(d0_req_ready), .req_we_i(1'b1),
        .req_addr_i(d0_req_addr), .req_size_i(2'b10), .req_unsigned_i(1'b0),
        .req_wdata_i(d0_req_wdata),
        .rsp_valid_o(d0_rsp_valid), .rsp_ready_i(d0_rsp_ready), .rsp_rdata_o(d0_rsp_rdata),
        .rsp_err_o(d0_rsp_err),
        .ram_addr_o(d0_ram_addr), .ram_wren_o(d0_ram_wren), .ram_wdata_o(d0_ram_wdata),
        .ram_rdata_i(d0_ram_rdata)
    );

    // Four byte-lane RAMs with combinational read and clocked write.
    logic [7:0] lane_mem [4][16384];
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++)
            if (ram_wren[l]) lane_mem[l][ram_addr[l*14 +: 14]] <= ram_wdata[l*8 +: 8];
    end
    always_comb begin
        ram_rdata = '0;
        for (int l = 0; l < 4; l++) ram_rdata[l*8 +: 8] = lane_mem[l][ram_addr[l*14 +: 14]];
    end

    // Reference model: flat byte memory, byte address A.
    logic [7:0] ref_mem [65536];
    int n_vec  = 0;
    int n_miss = 0;

    logic        t_ready, t_rv, t_re;
    logic [55:0] t_addr;
    logic [3:0]  t_wren;
    logic [31:0] t_wdata, t_rd;
    logic        m_err;
    logic [31:0] m_rd;

    task automatic model_op(input bit mis, input bit we, input int a, input int sz, input bit uns,
                            input logic [31:0] wd, output logic e, output logic [31:0] rd);
        int n;
        longint v;
        n  = (sz == 0) ? 1 : (sz == 1) ? 2 : (sz == 2) ? 4 : 0;
        e  = (n == 0) || (!mis && (a % n) != 0) || (a + n > 65536);
        rd = '0;
        if (!e) begin
            if (we) begin
                for (int b = 0; b < n; b++) ref_mem[a + b] = wd[8*b +: 8];
            end else begin
                v = 0;
                for (int b = 0; b < n; b++) v = v + longint'(ref_mem[a + b]) * (longint'(1) << (8*b));
                if (!uns && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
                rd = v[31:0];
            end
        end
    endtask

    task automatic xact(input bit we, input logic [15:0] a, input logic [1:0] sz, input bit uns,
                        input logic [31:0] wd,
                        output logic acc_ready, output logic [55:0] acc_addr, output logic [3:0] acc_wren,
                        output logic [31:0] acc_wdata, output logic rv, output logic [31:0] rd,
                        output logic re);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz; req_uns = uns; req_wdata = wd;
        rsp_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        acc_ready = req_ready; acc_addr = ram_addr; acc_wren = ram_wren; acc_wdata = ram_wdata;
        @(posedge clk);
        @(negedge clk);
        rv = rsp_valid; rd = rsp_rdata; re = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    task test_reset;
        #12;
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_vec++; if (rsp_err !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_rsp_err got %b exp 0", rsp_err); end
        n_vec++; if (rsp_rdata !== 32'd0) begin n_miss++; $display("[TB] FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
        n_vec++; if (ram_wren !== 4'd0) begin n_miss++; $display("[TB] FAIL reset_wren got %b exp 0", ram_wren); end
        n_vec++; if (ram_addr !== 56'd0) begin n_miss++; $display("[TB] FAIL reset_addr got %h exp 0", ram_addr); end
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL reset_ready got %b exp 1", req_ready); end
        @(negedge clk); rst = 1'b0;
    endtask

    task test_aligned;
        model_op(1'b1, 1'b1, 'h10, 2, 1'b0, 32'hDEADBEEF, m_err, m_rd);
        xact(1'b1, 16'h0010, 2'b10, 1'b0, 32'hDEADBEEF, t_ready, t_addr, t_wren, t_wdata, t_rv, t_rd, t_re);
        n_vec++; if (t_addr !== {4{14'd4}}) begin n_miss++; $display("[TB] FAIL sw_addr got %h exp %h", t_addr, {4{14'd4}}); end
        n_vec++; if (t_wren !== 4'b1111) begin n_miss++; $display("[TB] FAIL sw_wren got %b exp 1111", t_wren); end
        n_vec++; if (t_wdata !== 32'hDEADBEEF) begin n_miss++; $display("[TB] FAIL sw_wdata got %h exp deadbeef", t_wdata); end
        n_vec++; if (t_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL sw_ready_access got %b exp 0", t_ready); end
        n_vec++; if (t_rv !== 1'b1) begin n_miss++; $display("[TB] FAIL sw_rsp_cycle2 got %b exp 1", t_rv); end
        n_vec++; if (t_re !== 1'b0) begin n_miss++; $display("[TB] FAIL sw_err got %b exp 0", t_re); end
        n_vec++; if (t_rd !== 32'd0) begin n_miss++; $display("[TB] FAIL sw_rdata got %h exp 0", t_rd); end
        model_op(1'b1, 1'b0, 'h10, 2, 1'b0, 32'd0, m_err, m_rd);
        xact(1'b0, 16'h0010, 2'b10, 1'b0, 32'd0, t_ready, t_addr, t_wren, t_wdata, t_rv, t_rd, t_re);
        n_vec++; if (t_rd !== 32'hDEADBEEF) begin n_miss++; $display("[TB] FAIL lw_rdata got %h exp deadbeef", t_rd); end
        n_vec++; if (t_wren !== 4'b0000) begin n_miss++; $display("[TB] FAIL lw_wren got %b exp 0000", t_wren); end
    endtask

    task test_subword;
        logic [15:0] a_t [4];
        logic [1:0]  s_t [4];
        bit          u_t [4];
        logic [31:0] e_t [4];
        a_t = '{16'h0013, 16'h0013, 16'h0012, 16'h0010};
        s_t = '{2'b00, 2'b00, 2'b01, 2'b01};
        u_t = '{1'b0, 1'b1, 1'b0, 1'b1};
        e_t = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, a_t[i], s_t[i], u_t[i], 32'd0, t_ready, t_addr, t_wren, t_wdata, t_rv, t_rd, t_re);
            n_vec++;
            if (t_rd !== e_t[i] || t_re !== 1'b0) begin
                n_miss++; $display("[TB] FAIL subword_%0d got %h err %b exp %h err 0", i, t_rd, t_re, e_t[i]);
            end
        end
    endtask

    task test_misaligned;
        logic d0_seen_wren, d0_rv, d0_re;
        logic [31:0] d0_rd;
        model_op(1'b1, 1'b1, 'h16, 2, 1'b0, 32'h11223344, m_err, m_rd);
        xact(1'b1, 16'h0016, 2'b10, 1'b0, 32'h11223344, t_ready, t_addr, t_wren, t_wdata, t_rv, t_rd, t_re);
        // Lanes 3..0 word addresses 5,5,6,6.
        n_vec++; if (t_addr !== {14'd5, 14'd5, 14'd6, 14'd6}) begin n_miss++; $display("[TB] FAIL mis_addr got %h exp %h", t_addr, {14'd5, 14'd5, 14'd6, 14'd6}); end
        n_vec++; if (t_wren !== 4'b1111) begin n_miss++; $display("[TB] FAIL mis_wren got %b exp 1111", t_wren); end
        // Byte b goes to lane (2+b)&3: lane2=44, lane3=33, lane0=22, lane1=11.
        n_vec++; if (t_wdata !== 32'h33441122) begin n_miss++; $display("[TB] FAIL mis_wdata got %h exp 33441122", t_wdata); end
        n_vec++; if (t_re !== 1'b0) begin n_miss++; $display("[TB] FAIL mis_err got %b exp 0", t_re); end
        xact(1'b0, 16'h0016, 2'b10, 1'b0, 32'd0, t_ready, t_addr, t_wren, t_wdata, t_rv, t_rd, t_re);
        n_vec++; if (t_rd !== 32'h11223344) begin n_miss++; $display("[TB] FAIL mis_lw got %h exp 11223344", t_rd); end

        @(negedge clk);
        d0_req_valid = 1'b1; d0_req_addr = 16'h0016; d0_req_wdata = 32'h11223344; d0_rsp_ready = 1'b0;
        @(posedge clk); #1 d0_req_valid = 1'b0;
        @(negedge clk); d0_seen_wren = |d0_ram_wren;
        @(posedge clk);
        @(negedge clk);
        d0_seen_wren = d0_seen_wren | (|d0_ram_wren);
        d0_rv = d0_rsp_valid; d0_re = d0_rsp_err; d0_rd = d0_rsp_rdata;
        d0_rsp_ready = 1'b1;
        @(posedge clk); #1 d0_rsp_ready = 1'b0;
        n_vec++; if (d0_seen_wren !== 1'b0) begin n_miss++; $display("[TB] FAIL noalign_wren got %b exp 0", d0_seen_wren); end
        n_vec++; if (d0_rv !== 1'b1 || d0_re !== 1'b1) begin n_miss++; $display("[TB] FAIL noalign_err got valid %b err %b exp 1 1", d0_rv, d0_re); end
        n_vec++; if (d0_rd !== 32'd0) begin n_miss++; $display("[TB] FAIL noalign_rdata got %h exp 0", d0_rd); end
    endtask

    task test_errors;
        xact(1'b0, 16'hFFFF, 2'b01, 1'b0, 32'd0, t_ready, t_addr, t_wren, t_wdata, t_rv, t_rd, t_re);
        n_vec++; if (t_re !== 1'b1 || t_rd !== 32'd0) begin n_miss++; $display("[TB] FAIL lh_top got err %b rdata %h exp 1 0", t_re, t_rd); end
        xact(1'b1, 16'h0020, 2'b11, 1'b0, 32'hA5A5A5A5, t_ready, t_addr, t_wren, t_wdata, t_rv, t_rd, t_re);
        n_vec++; if (t_re !== 1'b1) begin n_miss++; $display("[TB] FAIL ill_err got %b exp 1", t_re); end
        n_vec++; if (t_wren !== 4'b0000) begin n_miss++; $display("[TB] FAIL ill_wren got %b exp 0000", t_wren); end
        model_op(1'b1, 1'b0, 'h20, 2, 1'b0, 32'd0, m_err, m_rd);
        xact(1'b0, 16'h0020, 2'b10, 1'b0, 32'd0, t_ready, t_addr, t_wren, t_wdata, t_rv, t_rd, t_re);
        n_vec++; if (t_rd !== m_rd) begin n_miss++; $display("[TB] FAIL ill_word8 got %h exp %h", t_rd, m_rd); end
        model_op(1'b1, 1'b0, 'hFFFF, 0, 1'b0, 32'd0, m_err, m_rd);
        xact(1'b0, 16'hFFFF, 2'b00, 1'b0, 32'd0, t_ready, t_addr, t_wren, t_wdata, t_rv, t_rd, t_re);
        n_vec++; if (t_re !== 1'b0 || t_addr[55:42] !== 14'd16383) begin n_miss++; $display("[TB] FAIL lb_top got err %b lane3 %0d exp 0 16383", t_re, t_addr[55:42]); end
        n_vec++; if (t_rd !== m_rd) begin n_miss++; $display("[TB] FAIL lb_top_data got %h exp %h", t_rd, m_rd); end
    endtask

    task test_back_to_back;
        model_op(1'b1, 1'b0, 'h25, 0, 1'b0, 32'd0, m_err, m_rd);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_size = 2'b10; req_uns = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk); #1 req_addr = 16'h0025; req_size = 2'b00;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL bp_ready_access got %b exp 0", req_ready); end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0 || ram_addr !== {4{14'd4}}) begin
                n_miss++; $display("[TB] FAIL bp_hold_%0d got valid %b data %h ready %b addr %h exp 1 deadbeef 0 %h",
                                   i, rsp_valid, rsp_rdata, req_ready, ram_addr, {4{14'd4}});
            end
            if (i < 2) @(posedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || ram_addr !== {4{14'd4}}) begin
            n_miss++; $display("[TB] FAIL bp_idle got ready %b valid %b addr %h exp 1 0 %h", req_ready, rsp_valid, ram_addr, {4{14'd4}});
        end
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (ram_addr !== {4{14'd9}}) begin n_miss++; $display("[TB] FAIL bp_pending_addr got %h exp %h", ram_addr, {4{14'd9}}); end
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== m_rd) begin n_miss++; $display("[TB] FAIL bp_pending_rsp got valid %b data %h exp 1 %h", rsp_valid, rsp_rdata, m_rd); end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    task test_reset_mid;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0040; req_size = 2'b10; req_uns = 1'b0;
        req_wdata = 32'hCAFEF00D; rsp_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (ram_wren !== 4'b1111) begin n_miss++; $display("[TB] FAIL rstmid_pre_wren got %b exp 1111", ram_wren); end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (ram_wren !== 4'b0000 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_miss++; $display("[TB] FAIL rstmid got wren %b valid %b ready %b exp 0000 0 1", ram_wren, rsp_valid, req_ready);
        end
        @(negedge clk); rst = 1'b0;
        model_op(1'b1, 1'b0, 'h40, 2, 1'b0, 32'd0, m_err, m_rd);
        xact(1'b0, 16'h0040, 2'b10, 1'b0, 32'd0, t_ready, t_addr, t_wren, t_wdata, t_rv, t_rd, t_re);
        n_vec++;
        if (t_rv !== 1'b1 || t_re !== 1'b0 || t_rd !== m_rd) begin
            n_miss++; $display("[TB] FAIL rstmid_lw got valid %b err %b data %h exp 1 0 %h", t_rv, t_re, t_rd, m_rd);
        end
    endtask

    task test_random;
        int a, sz, r, n, ln;
        bit we, uns;
        logic [31:0] wd, exp_wd, mask;
        logic [55:0] exp_addr;
        logic [3:0]  exp_wren;
        for (int k = 0; k < 60; k++) begin
            a   = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 47)) : 16'hFFF8 + int'($urandom_range(0, 7));
            r   = $urandom_range(0, 7);
            sz  = (r == 7) ? 3 : r % 3;
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            n   = (sz == 0) ? 1 : (sz == 1) ? 2 : (sz == 2) ? 4 : 0;
            exp_addr = '0; exp_wren = '0; exp_wd = '0; mask = '0;
            for (int l = 0; l < 4; l++) exp_addr[l*14 +: 14] = 14'(a / 4);
            for (int b = 0; b < n; b++) begin
                ln = (a + b) % 4;
                exp_addr[ln*14 +: 14] = 14'((a + b) / 4);
                exp_wren[ln] = 1'b1;
                exp_wd[ln*8 +: 8] = wd[8*b +: 8];
                mask[ln*8 +: 8] = 8'hFF;
            end
            model_op(1'b1, we, a, sz, uns, wd, m_err, m_rd);
            if (m_err || !we) exp_wren = '0;
            xact(we, 16'(a), 2'(sz), uns, wd, t_ready, t_addr, t_wren, t_wdata, t_rv, t_rd, t_re);
            n_vec++;
            if (t_rv !== 1'b1 || t_re !== m_err || t_rd !== m_rd) begin
                n_miss++; $display("[TB] FAIL rnd_%0d rsp a=%h sz=%0d we=%b got v%b e%b %h exp 1 e%b %h",
                                   k, a, sz, we, t_rv, t_re, t_rd, m_err, m_rd);
            end
            n_vec++;
            if (t_wren !== exp_wren) begin
                n_miss++; $display("[TB] FAIL rnd_%0d wren got %b exp %b", k, t_wren, exp_wren);
            end
            if (!m_err) begin
                n_vec++;
                if (t_addr !== exp_addr || (t_wdata & mask) !== (exp_wd & mask)) begin
                    n_miss++; $display("[TB] FAIL rnd_%0d lanes got %h/%h exp %h/%h", k, t_addr, t_wdata & mask, exp_addr, exp_wd & mask);
                end
            end
        end
    endtask

    initial begin
        for (int l = 0; l < 4; l++)
            for (int w = 0; w < 16384; w++) lane_mem[l][w] = 8'h00;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        test_reset;
        test_aligned;
        test_subword;
        test_misaligned;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
